// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : UART transmitter with input FIFO and runtime frame format
//               (5..DATA_WIDTH data bits, none/even/odd parity, 1/2 stop).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int DATA_WIDTH = 9,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic                       txd,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    input  logic [15:0]                prescale,
    input  logic [3:0]                 cfg_data_bits,
    input  logic [1:0]                 cfg_parity,
    input  logic                       cfg_stop2
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;
    logic                  r_ready_en;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    state_t                r_state;
    state_t                w_state_next;
    logic [18:0]           r_timer;
    logic [18:0]           r_reload;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [3:0]            r_nbits;
    logic [3:0]            r_bit_idx;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_stop2;
    logic                  r_stop_idx;
    logic                  r_txd;

    logic                  w_bit_end;
    logic                  w_last_data;
    logic                  w_last_stop;
    logic [15:0]           w_ps_eff;
    logic [18:0]           w_reload_new;
    logic [3:0]            w_nbits_new;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_par_en_new;
    logic                  w_par_bit_new;

    // ---------------- FIFO ----------------
    assign w_full        = (r_count == c_CW'(DEPTH));
    assign w_empty       = (r_count == '0);
    // Held low through reset so the source sees no acceptance until the first clean edge.
    assign s_axis_tready = r_ready_en && !w_full;
    assign w_push        = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- frame configuration captured at pop ----------------
    always_comb begin
        w_ps_eff     = (prescale == 16'd0) ? 16'd1 : prescale;
        w_reload_new = {w_ps_eff, 3'b000} - 19'd1;
        if (cfg_data_bits < 4'd5)
            w_nbits_new = 4'd5;
        else if (cfg_data_bits > 4'(DATA_WIDTH))
            w_nbits_new = 4'(DATA_WIDTH);
        else
            w_nbits_new = cfg_data_bits;
        w_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_mask[i] = (i < int'(w_nbits_new));
        end
        w_word        = r_mem[r_rd_ptr] & w_mask;
        w_par_en_new  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
        w_par_bit_new = (cfg_parity == 2'b10) ? ~^w_word : ^w_word;
    end

    // ---------------- FSM ----------------
    assign w_bit_end   = (r_timer == 19'd0);
    assign w_last_data = (r_bit_idx == r_nbits - 4'd1);
    assign w_last_stop = (r_stop_idx == r_stop2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end && w_last_data)
                    w_state_next = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_bit_end) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                // Back-to-back frames: go straight to START with no idle clock.
                if (w_bit_end && w_last_stop) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer    <= '0;
            r_reload   <= '0;
            r_shift    <= '0;
            r_nbits    <= 4'd5;
            r_bit_idx  <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
            r_txd      <= 1'b1;
        end else if (w_pop) begin
            r_timer   <= w_reload_new;
            r_reload  <= w_reload_new;
            r_shift   <= w_word;
            r_nbits   <= w_nbits_new;
            r_par_en  <= w_par_en_new;
            r_par_bit <= w_par_bit_new;
            r_stop2   <= cfg_stop2;
            r_txd     <= 1'b0;
        end else if (r_state != ST_IDLE) begin
            if (w_bit_end) begin
                r_timer <= r_reload;
                case (r_state)
                    ST_START: begin
                        r_txd     <= r_shift[0];
                        r_bit_idx <= '0;
                    end
                    ST_DATA: begin
                        if (w_last_data) begin
                            r_stop_idx <= 1'b0;
                            r_txd      <= r_par_en ? r_par_bit : 1'b1;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_txd     <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        r_stop_idx <= 1'b0;
                        r_txd      <= 1'b1;
                    end
                    ST_STOP: begin
                        r_stop_idx <= 1'b1;
                        r_txd      <= 1'b1;
                    end
                    default: r_txd <= 1'b1;
                endcase
            end else begin
                r_timer <= r_timer - 19'd1;
            end
        end
    end

    assign txd        = r_txd;
    assign busy       = (r_state != ST_IDLE) || !w_empty;
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Directed self-checking bench for uart_tx_cfg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    logic        clk;
    logic        rst;
    logic [8:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        txd;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [15:0] prescale;
    logic [3:0]  cfg_data_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;

    int n_vec;
    int n_err;

    uart_tx_cfg #(.DATA_WIDTH(9), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .txd           (txd),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .prescale      (prescale),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [8:0] d);
        @(negedge clk);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    // Returns at the first falling-edge sample with txd low (start bit).
    task automatic wait_start(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!txd) break;
        end
        chk({tag, "_start"}, 32'(txd), 32'd0);
    endtask

    // Caller sits skip clocks past the first start-bit sample; bits are sampled mid-period.
    task automatic frame(input string tag, input int n, input int bp, input logic [15:0] exp,
                         input int skip, input logic txd_after, input logic busy_after);
        for (int k = 0; k < n; k++) begin
            repeat ((k == 0) ? (bp / 2 - skip) : bp) @(negedge clk);
            chk($sformatf("%s_b%0d", tag, k), 32'(txd), 32'(exp[k]));
        end
        repeat (bp / 2 - 1) @(negedge clk);
        chk({tag, "_lastclk_txd"}, 32'(txd), 32'd1);
        chk({tag, "_lastclk_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_after_txd"}, 32'(txd), 32'(txd_after));
        chk({tag, "_after_busy"}, 32'(busy), 32'(busy_after));
    endtask

    initial begin
        logic saw_low;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        prescale = 16'd1;
        cfg_data_bits = 4'd8;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_tready_pre", 32'(s_axis_tready), 32'd0);
        @(negedge clk);
        chk("rel_tready_post", 32'(s_axis_tready), 32'd1);

        // 8N1 0x55, prescale 1: latency and bit pattern
        @(negedge clk);
        s_axis_tdata  = 9'h055;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        chk("t1_cnt_after_push", 32'(fifo_count), 32'd1);
        chk("t1_txd_after_push", 32'(txd), 32'd1);
        chk("t1_busy_after_push", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_txd_after_pop", 32'(txd), 32'd0);
        chk("t1_cnt_after_pop", 32'(fifo_count), 32'd0);
        frame("t1", 10, 8, 16'({1'b1, 8'h55, 1'b0}), 0, 1'b1, 1'b0);

        // 7E1 0x41 -> parity 0
        cfg_data_bits = 4'd7;
        cfg_parity = 2'b01;
        push(9'h041);
        wait_start("t2e");
        frame("t2e", 10, 8, 16'({1'b1, 1'b0, 7'h41, 1'b0}), 0, 1'b1, 1'b0);

        // 7O1 0xC1: bit 7 is masked off, parity 1
        cfg_parity = 2'b10;
        push(9'h0C1);
        wait_start("t2o");
        frame("t2o", 10, 8, 16'({1'b1, 1'b1, 7'h41, 1'b0}), 0, 1'b1, 1'b0);

        // 9N2 0x1FF; config scrambled mid-frame must not matter
        cfg_data_bits = 4'd9;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b1;
        push(9'h1FF);
        wait_start("t3");
        cfg_data_bits = 4'd5;
        cfg_parity = 2'b01;
        cfg_stop2 = 1'b0;
        prescale = 16'd3;
        frame("t3", 12, 8, 16'({2'b11, 9'h1FF, 1'b0}), 0, 1'b1, 1'b0);

        // cfg_data_bits above DATA_WIDTH clamps to 9
        prescale = 16'd1;
        cfg_data_bits = 4'd15;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        push(9'h100);
        wait_start("t3c");
        frame("t3c", 11, 8, 16'({1'b1, 9'h100, 1'b0}), 0, 1'b1, 1'b0);

        // Five words back to back, prescale 2: fill, full hold, abutting frames
        prescale = 16'd2;
        cfg_data_bits = 4'd8;
        @(negedge clk);
        s_axis_tdata  = 9'h001;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        chk("t4_cnt1", 32'(fifo_count), 32'd1);
        s_axis_tdata = 9'h080;
        @(negedge clk);
        chk("t4_start", 32'(txd), 32'd0);
        chk("t4_cnt_pushpop", 32'(fifo_count), 32'd1);
        s_axis_tdata = 9'h0FF;
        @(negedge clk);
        s_axis_tdata = 9'h03C;
        @(negedge clk);
        chk("t4_tready_c3", 32'(s_axis_tready), 32'd1);
        chk("t4_cnt3", 32'(fifo_count), 32'd3);
        s_axis_tdata = 9'h0A5;
        @(negedge clk);
        chk("t4_tready_full", 32'(s_axis_tready), 32'd0);
        chk("t4_cnt_full", 32'(fifo_count), 32'd4);
        s_axis_tdata = 9'h1EE;
        @(negedge clk);
        chk("t4_cnt_hold", 32'(fifo_count), 32'd4);
        s_axis_tvalid = 1'b0;
        frame("t4w0", 10, 16, 16'({1'b1, 8'h01, 1'b0}), 4, 1'b0, 1'b1);
        frame("t4w1", 10, 16, 16'({1'b1, 8'h80, 1'b0}), 0, 1'b0, 1'b1);
        frame("t4w2", 10, 16, 16'({1'b1, 8'hFF, 1'b0}), 0, 1'b0, 1'b1);
        frame("t4w3", 10, 16, 16'({1'b1, 8'h3C, 1'b0}), 0, 1'b0, 1'b1);
        frame("t4w4", 10, 16, 16'({1'b1, 8'hA5, 1'b0}), 0, 1'b1, 1'b0);

        // Reset mid-DATA with 3 words queued
        prescale = 16'd1;
        @(negedge clk);
        s_axis_tdata  = 9'h0FE;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        s_axis_tdata = 9'h011;
        @(negedge clk);
        s_axis_tdata = 9'h022;
        @(negedge clk);
        s_axis_tdata = 9'h033;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        chk("t5_cnt3", 32'(fifo_count), 32'd3);
        repeat (10) @(negedge clk);
        chk("t5_txd_data0", 32'(txd), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_txd", 32'(txd), 32'd1);
        chk("t5_async_cnt", 32'(fifo_count), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_tready", 32'(s_axis_tready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        chk("t5_no_frame", 32'(saw_low), 32'd0);
        chk("t5_busy_idle", 32'(busy), 32'd0);
        chk("t5_tready_idle", 32'(s_axis_tready), 32'd1);

        // prescale 0 -> 1, cfg_data_bits 3 -> 5
        prescale = 16'd0;
        cfg_data_bits = 4'd3;
        push(9'h0EA);
        wait_start("t6");
        frame("t6", 7, 8, 16'({1'b1, 5'h0A, 1'b0}), 0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
